// File: rtl/dac_control_fsm_if.sv
// UART-side and I2C-master-side signals of the DAC command interpreter.
// master = the interpreter, slave = the UART/I2C blocks around it.
interface dac_control_fsm_if;
    logic [7:0]  UART_Rx;
    logic        UART_DataReady;
    logic [7:0]  UART_Tx;
    logic [6:0]  I2Caddr;
    logic [15:0] I2Cdata;
    logic        I2Cbytes;
    logic        I2Cr_w;
    logic        I2C_load;
    logic        I2CBusy;
    logic        I2CDataReady;

    modport master (
        input  UART_Rx, UART_DataReady, I2CBusy, I2CDataReady,
        output UART_Tx, I2Caddr, I2Cdata, I2Cbytes, I2Cr_w, I2C_load
    );

    modport slave (
        output UART_Rx, UART_DataReady, I2CBusy, I2CDataReady,
        input  UART_Tx, I2Caddr, I2Cdata, I2Cbytes, I2Cr_w, I2C_load
    );
endinterface

// File: rtl/dac_control_fsm.sv
// Turns "V" + ten ASCII binary digits into one 2-byte I2C write to a 10-bit DAC,
// reporting 'K' on completion and 'E' on a bad byte or a master that never starts.
module dac_control_fsm (
    input  logic                      clk,
    input  logic                      rst,
    dac_control_fsm_if.master         bus
);
    localparam logic [6:0] DAC_ADDR = 7'h0C;
    localparam logic [3:0] NDIGITS  = 4'd10;
    localparam logic [7:0] TIMEOUT  = 8'd255;
    localparam logic [7:0] CH_V     = 8'h56;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_1     = 8'h31;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_K     = 8'h4B;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WAIT_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_d,     w_d_nxt;
    logic [3:0]  r_cnt,   w_cnt_nxt;
    logic [7:0]  r_tmo,   w_tmo_nxt;
    logic [7:0]  r_tx,    w_tx_nxt;
    logic [15:0] r_data,  w_data_nxt;
    logic        w_strobe;
    logic        w_digit;
    logic        w_unused;

    assign w_strobe = bus.UART_DataReady;
    assign w_digit  = (bus.UART_Rx == CH_0) || (bus.UART_Rx == CH_1);
    // Write-only block: read data from the master is never consumed.
    assign w_unused = bus.I2CDataReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_d     <= '0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_tx    <= 8'h00;
            r_data  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
            r_tx    <= w_tx_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        w_tx_nxt    = r_tx;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                if (w_strobe && bus.UART_Rx == CH_V) begin
                    w_d_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 8'h00;
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_strobe) begin
                    if (w_digit) begin
                        w_d_nxt   = {r_d[8:0], bus.UART_Rx[0]};
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt == NDIGITS - 4'd1)
                            w_state_nxt = S_WAIT_IDLE;
                    end else if (bus.UART_Rx == CH_V) begin
                        w_d_nxt   = '0;
                        w_cnt_nxt = '0;
                    end else begin
                        w_tx_nxt    = CH_E;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // AD5311 frame: 2 don't-care, PD1:PD0 = 00 (normal), D9..D0, 2 don't-care.
                if (!bus.I2CBusy) begin
                    w_data_nxt  = {2'b00, 2'b00, r_d, 2'b00};
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_tmo_nxt   = '0;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.I2CBusy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_tmo == TIMEOUT - 8'd1) begin
                    w_tx_nxt    = CH_E;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.I2CBusy) begin
                    w_tx_nxt    = CH_K;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.UART_Tx  = r_tx;
    assign bus.I2Cdata  = r_data;
    assign bus.I2C_load = (r_state == S_LOAD);
    assign bus.I2Caddr  = DAC_ADDR;
    assign bus.I2Cbytes = 1'b1;
    assign bus.I2Cr_w   = 1'b0;
endmodule

// File: tb/tb_dac_control_fsm.sv
// Scenario bench for dac_control_fsm: directed command sequences plus randomized
// commands checked against an arithmetic model of the expected DAC frame.
module tb_dac_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    dac_control_fsm_if bus();

    dac_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int load_cnt  = 0;
    int load_wide = 0;
    bit prev_load = 1'b0;

    // Counts I2C_load pulses and flags any pulse wider than one cycle.
    always @(negedge clk) begin
        if (bus.I2C_load === 1'b1) begin
            load_cnt++;
            if (prev_load) load_wide++;
        end
        prev_load = (bus.I2C_load === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected frame: the ten command bits, as a number, times four.
    function automatic logic [15:0] model_frame(input int value);
        return 16'(value * 4);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.UART_Rx = b;
        bus.UART_DataReady = 1'b1;
        tick();
        bus.UART_DataReady = 1'b0;
        tick(gap);
    endtask

    task automatic send_digits(input logic [9:0] v, input int gap);
        for (int i = 9; i >= 0; i--)
            send(v[i] ? 8'h31 : 8'h30, (i == 0) ? 0 : gap);
    endtask

    task automatic finish_txn(input int hold);
        bus.I2CBusy = 1'b1;
        tick(hold);
        bus.I2CBusy = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        n_tests++; if (bus.UART_Tx !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got %h want 00", bus.UART_Tx); end
        n_tests++; if (bus.I2Cdata !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", bus.I2Cdata); end
        n_tests++; if (bus.I2C_load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0", bus.I2C_load); end
        n_tests++; if (bus.I2Caddr !== 7'h0C) begin n_fail++; $display("FAIL reset_addr: got %h want 0c", bus.I2Caddr); end
        n_tests++; if ({bus.I2Cbytes, bus.I2Cr_w} !== 2'b10) begin n_fail++; $display("FAIL reset_bytes_rw: got %b want 10", {bus.I2Cbytes, bus.I2Cr_w}); end
    endtask

    task automatic test_basic();
        int base = load_cnt;
        send(8'h56, 5);
        send_digits(10'b1010101010, 5);
        n_tests++; if (bus.I2C_load !== 1'b0) begin n_fail++; $display("FAIL basic_load_early: got %b want 0", bus.I2C_load); end
        tick();
        n_tests++; if (bus.I2C_load !== 1'b1) begin n_fail++; $display("FAIL basic_load: got %b want 1", bus.I2C_load); end
        n_tests++; if (bus.I2Cdata !== 16'h0AA8) begin n_fail++; $display("FAIL basic_data: got %h want 0aa8", bus.I2Cdata); end
        n_tests++; if ({bus.I2Caddr, bus.I2Cbytes, bus.I2Cr_w} !== {7'h0C, 1'b1, 1'b0}) begin n_fail++; $display("FAIL basic_const: got %h/%b/%b want 0c/1/0", bus.I2Caddr, bus.I2Cbytes, bus.I2Cr_w); end
        tick();
        n_tests++; if (bus.I2C_load !== 1'b0) begin n_fail++; $display("FAIL basic_load_width: got %b want 0", bus.I2C_load); end
        tick(2);
        bus.I2CBusy = 1'b1;
        tick(3);
        send(8'h56, 2);
        send(8'h31, 2);
        tick(12);
        bus.I2CBusy = 1'b0;
        tick(2);
        n_tests++; if (bus.UART_Tx !== 8'h4B) begin n_fail++; $display("FAIL basic_tx_k: got %h want 4b", bus.UART_Tx); end
        // The V sent while busy must not have opened a command.
        send_digits(10'h3FF, 1);
        tick(3);
        n_tests++; if (load_cnt - base !== 1) begin n_fail++; $display("FAIL basic_load_count: got %0d want 1", load_cnt - base); end
    endtask

    task automatic test_abort();
        int base = load_cnt;
        send(8'h56, 2);
        n_tests++; if (bus.UART_Tx !== 8'h00) begin n_fail++; $display("FAIL abort_tx_clear: got %h want 00", bus.UART_Tx); end
        send(8'h31, 2);
        send(8'h31, 2);
        send(8'h78, 0);
        n_tests++; if (bus.UART_Tx !== 8'h45) begin n_fail++; $display("FAIL abort_tx_e: got %h want 45", bus.UART_Tx); end
        tick(3);
        n_tests++; if (load_cnt - base !== 0) begin n_fail++; $display("FAIL abort_no_load: got %0d want 0", load_cnt - base); end
        send(8'h56, 1);
        send_digits(10'h3FF, 1);
        tick();
        n_tests++; if (bus.I2C_load !== 1'b1 || bus.I2Cdata !== 16'h0FFC) begin n_fail++; $display("FAIL abort_retry: got load %b data %h want 1 0ffc", bus.I2C_load, bus.I2Cdata); end
        tick();
        finish_txn(5);
        n_tests++; if (bus.UART_Tx !== 8'h4B) begin n_fail++; $display("FAIL abort_retry_k: got %h want 4b", bus.UART_Tx); end
    endtask

    task automatic test_ignore_restart();
        int base = load_cnt;
        send(8'h41, 2);
        send(8'h31, 2);
        send(8'h30, 2);
        tick(2);
        n_tests++; if (bus.UART_Tx !== 8'h4B || bus.I2Cdata !== 16'h0FFC || load_cnt != base) begin n_fail++; $display("FAIL ignore_idle: got tx %h data %h loads %0d want 4b 0ffc 0", bus.UART_Tx, bus.I2Cdata, load_cnt - base); end
        send(8'h56, 1);
        send(8'h31, 1);
        send(8'h56, 1);
        send_digits(10'h000, 1);
        tick();
        n_tests++; if (bus.I2C_load !== 1'b1 || bus.I2Cdata !== 16'h0000) begin n_fail++; $display("FAIL restart_frame: got load %b data %h want 1 0000", bus.I2C_load, bus.I2Cdata); end
        tick();
        finish_txn(3);
        n_tests++; if (load_cnt - base !== 1) begin n_fail++; $display("FAIL restart_load_count: got %0d want 1", load_cnt - base); end
    endtask

    task automatic test_busy_hold_timeout();
        int base = load_cnt;
        logic [9:0] v = 10'($urandom) | 10'h200;
        bus.I2CBusy = 1'b1;
        send(8'h56, 1);
        send_digits(v, 1);
        tick(6);
        n_tests++; if (load_cnt - base !== 0) begin n_fail++; $display("FAIL hold_no_load: got %0d want 0", load_cnt - base); end
        bus.I2CBusy = 1'b0;
        tick();
        n_tests++; if (bus.I2C_load !== 1'b1 || bus.I2Cdata !== model_frame(int'(v))) begin n_fail++; $display("FAIL hold_load: got load %b data %h want 1 %h", bus.I2C_load, bus.I2Cdata, model_frame(int'(v))); end
        tick();
        n_tests++; if (bus.I2C_load !== 1'b0) begin n_fail++; $display("FAIL hold_load_width: got %b want 0", bus.I2C_load); end
        tick(254);
        n_tests++; if (bus.UART_Tx !== 8'h00) begin n_fail++; $display("FAIL timeout_early: got %h want 00", bus.UART_Tx); end
        tick();
        n_tests++; if (bus.UART_Tx !== 8'h45) begin n_fail++; $display("FAIL timeout_e: got %h want 45", bus.UART_Tx); end
        n_tests++; if (load_cnt - base !== 1) begin n_fail++; $display("FAIL timeout_loads: got %0d want 1", load_cnt - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [9:0] v = 10'($urandom) | 10'h001;
        send(8'h56, 1);
        for (int i = 0; i < 5; i++) send(8'h31, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (bus.UART_Tx !== 8'h00 || bus.I2Cdata !== 16'h0000 || bus.I2C_load !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: got tx %h data %h load %b want 00 0000 0", bus.UART_Tx, bus.I2Cdata, bus.I2C_load); end
        base = load_cnt;
        send_digits(10'h3FF, 1);
        tick(3);
        n_tests++; if (load_cnt - base !== 0) begin n_fail++; $display("FAIL midreset_idle: got %0d loads want 0", load_cnt - base); end
        send(8'h56, 1);
        send_digits(v, 1);
        tick();
        n_tests++; if (bus.I2C_load !== 1'b1 || bus.I2Cdata !== model_frame(int'(v))) begin n_fail++; $display("FAIL midreset_cmd: got load %b data %h want 1 %h", bus.I2C_load, bus.I2Cdata, model_frame(int'(v))); end
        tick();
        bus.I2CBusy = 1'b1;
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.I2CBusy = 1'b0;
        n_tests++; if (bus.I2Cdata !== 16'h0000 || bus.I2C_load !== 1'b0) begin n_fail++; $display("FAIL txn_reset: got data %h load %b want 0000 0", bus.I2Cdata, bus.I2C_load); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int base = load_cnt;
            int mode = int'($urandom_range(0, 2));
            int k    = int'($urandom_range(0, 9));
            int gap  = int'($urandom_range(0, 2));
            logic [9:0] v = 10'($urandom);
            int value = 0;
            for (int i = 9; i >= 0; i--) value = value * 2 + int'(v[i]);
            send(8'h56, gap);
            if (mode != 0)
                for (int i = 0; i < k; i++) send($urandom_range(0, 1) ? 8'h31 : 8'h30, gap);
            if (mode == 1) begin
                send(8'($urandom_range(8'h61, 8'h7A)), 0);
                tick(3);
                n_tests++; if (bus.UART_Tx !== 8'h45 || load_cnt != base) begin n_fail++; $display("FAIL rand_abort[%0d]: got tx %h loads %0d want 45 0", it, bus.UART_Tx, load_cnt - base); end
            end else begin
                if (mode == 2) send(8'h56, gap);
                send_digits(v, gap);
                tick();
                n_tests++; if (bus.I2C_load !== 1'b1 || bus.I2Cdata !== model_frame(value)) begin n_fail++; $display("FAIL rand_frame[%0d]: got load %b data %h want 1 %h", it, bus.I2C_load, bus.I2Cdata, model_frame(value)); end
                tick();
                finish_txn(int'($urandom_range(1, 30)));
                n_tests++; if (bus.UART_Tx !== 8'h4B || load_cnt - base != 1) begin n_fail++; $display("FAIL rand_done[%0d]: got tx %h loads %0d want 4b 1", it, bus.UART_Tx, load_cnt - base); end
            end
        end
        n_tests++; if (load_wide !== 0) begin n_fail++; $display("FAIL load_pulse_width: got %0d wide pulses want 0", load_wide); end
    endtask

    initial begin
        bus.UART_Rx        = 8'h00;
        bus.UART_DataReady = 1'b0;
        bus.I2CBusy        = 1'b0;
        bus.I2CDataReady   = 1'b0;
        test_reset();
        test_basic();
        test_abort();
        test_ignore_restart();
        test_busy_hold_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
